// File: rtl/fft_input_buffer.sv
// ============================================================================
// Module   : fft_input_buffer
// Purpose  : Ping-pong 2x64 complex sample buffer feeding the radix-2 FFT
//            engine; optional bit-reversed write order via FFT_INPUT_BITREV_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_input_buffer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start_i,
  input  logic          din_valid_i,
  input  logic [DW-1:0] din_re_i,
  input  logic [DW-1:0] din_im_i,
  output logic          bank_ready_o,
  output logic          bank_sel_o,
  output logic          engine_busy_o,
  input  logic          rd_en_i,
  input  logic [5:0]    rd_addr_i,
  output logic [DW-1:0] rd_re_o,
  output logic [DW-1:0] rd_im_o,
  input  logic          fft_done_i,
  output logic          overflow_o
);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_BUSY} bank_st_t;
  typedef enum logic [0:0] {W_IDLE, W_FILL} wr_st_t;

  function automatic logic [5:0] addr_map(input logic [5:0] n);
`ifdef FFT_INPUT_BITREV_EN
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = n[5-i];
    return r;
`else
    return n;
`endif
  endfunction

  bank_st_t        bank_q [2];
  bank_st_t        bank_d [2];
  wr_st_t          wr_state_q, wr_state_d;
  logic            wr_bank_q, wr_bank_d;
  logic [5:0]      wr_cnt_q, wr_cnt_d;
  logic            overflow_q, overflow_d;
  logic            bank_ready_q, bank_ready_d;
  logic            bank_sel_q, bank_sel_d;
  logic [DW-1:0]   rd_re_q, rd_im_q;
  logic            we;
  logic            wbank;
  logic [5:0]      waddr;
  logic            busy;
  logic [2*DW-1:0] mem_q [0:127];

  assign busy = (bank_q[0] == B_BUSY) || (bank_q[1] == B_BUSY);

  always_comb begin
    bank_d[0]    = bank_q[0];
    bank_d[1]    = bank_q[1];
    wr_state_d   = wr_state_q;
    wr_bank_d    = wr_bank_q;
    wr_cnt_d     = wr_cnt_q;
    overflow_d   = overflow_q;
    bank_ready_d = 1'b0;
    bank_sel_d   = bank_sel_q;
    we           = 1'b0;
    wbank        = wr_bank_q;
    waddr        = addr_map(wr_cnt_q);

    case (wr_state_q)
      W_IDLE: begin
        if (frame_start_i && din_valid_i) begin
          // Bank choice looks only at pre-edge state, so a bank freed this cycle is not yet EMPTY.
          if (bank_q[0] == B_EMPTY || bank_q[1] == B_EMPTY) begin
            wbank         = (bank_q[0] == B_EMPTY) ? 1'b0 : 1'b1;
            wr_bank_d     = wbank;
            bank_d[wbank] = B_FILLING;
            we            = 1'b1;
            waddr         = addr_map(6'd0);
            wr_cnt_d      = 6'd1;
            wr_state_d    = W_FILL;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      W_FILL: begin
        if (din_valid_i) begin
          we = 1'b1;
          if (frame_start_i) begin
            waddr    = addr_map(6'd0);
            wr_cnt_d = 6'd1;
          end else begin
            wr_cnt_d = wr_cnt_q + 6'd1;
            if (wr_cnt_q == 6'd63) begin
              bank_d[wr_bank_q] = B_FULL;
              wr_state_d        = W_IDLE;
            end
          end
        end
      end
      default: wr_state_d = W_IDLE;
    endcase

    if (fft_done_i) begin
      for (int b = 0; b < 2; b++)
        if (bank_q[b] == B_BUSY) bank_d[b] = B_EMPTY;
    end

    if (!busy) begin
      if (bank_q[0] == B_FULL) begin
        bank_d[0]    = B_BUSY;
        bank_sel_d   = 1'b0;
        bank_ready_d = 1'b1;
      end else if (bank_q[1] == B_FULL) begin
        bank_d[1]    = B_BUSY;
        bank_sel_d   = 1'b1;
        bank_ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0]    <= B_EMPTY;
      bank_q[1]    <= B_EMPTY;
      wr_state_q   <= W_IDLE;
      wr_bank_q    <= 1'b0;
      wr_cnt_q     <= 6'd0;
      overflow_q   <= 1'b0;
      bank_ready_q <= 1'b0;
      bank_sel_q   <= 1'b0;
      rd_re_q      <= '0;
      rd_im_q      <= '0;
    end else begin
      bank_q[0]    <= bank_d[0];
      bank_q[1]    <= bank_d[1];
      wr_state_q   <= wr_state_d;
      wr_bank_q    <= wr_bank_d;
      wr_cnt_q     <= wr_cnt_d;
      overflow_q   <= overflow_d;
      bank_ready_q <= bank_ready_d;
      bank_sel_q   <= bank_sel_d;
      if (rd_en_i) begin
        if (busy) begin
          {rd_re_q, rd_im_q} <= mem_q[{bank_sel_q, rd_addr_i}];
        end else begin
          rd_re_q <= '0;
          rd_im_q <= '0;
        end
      end
    end
  end

  // Sample storage carries no reset.
  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[{wbank, waddr}] <= {din_re_i, din_im_i};
  end

  assign bank_ready_o  = bank_ready_q;
  assign bank_sel_o    = bank_sel_q;
  assign engine_busy_o = busy;
  assign rd_re_o       = rd_re_q;
  assign rd_im_o       = rd_im_q;
  assign overflow_o    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_input_buffer.sv
// ============================================================================
// Module   : tb_fft_input_buffer
// Purpose  : Self-checking bench for fft_input_buffer with a read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_input_buffer;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din_re = '0;
  logic [DW-1:0] din_im = '0;
  logic          bank_ready, bank_sel, engine_busy, overflow;
  logic          rd_en = 1'b0;
  logic [5:0]    rd_addr = '0;
  logic [DW-1:0] rd_re, rd_im;
  logic          fft_done = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int rdy_cnt  = 0;
  logic [2*DW-1:0] sb_q [$];

  fft_input_buffer #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .frame_start_i(frame_start), .din_valid_i(din_valid),
    .din_re_i(din_re), .din_im_i(din_im),
    .bank_ready_o(bank_ready), .bank_sel_o(bank_sel), .engine_busy_o(engine_busy),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_re_o(rd_re), .rd_im_o(rd_im),
    .fft_done_i(fft_done), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bank_ready) rdy_cnt <= rdy_cnt + 1;

  function automatic logic [5:0] sample_of(input logic [5:0] a);
`ifdef FFT_INPUT_BITREV_EN
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = a[5-i];
    return r;
`else
    return a;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input int v, input logic fs, input logic done);
    din_valid   = 1'b1;
    frame_start = fs;
    fft_done    = done;
    din_re      = DW'(v);
    din_im      = DW'(-v);
    tick();
    din_valid   = 1'b0;
    frame_start = 1'b0;
    fft_done    = 1'b0;
  endtask

  // Sends samples base+0..base+cnt-1; optional fft_done on the last one and a 5-cycle gap.
  task automatic send_frame(input int base, input int cnt, input logic done_last, input int gap_at);
    for (int n = 0; n < cnt; n++) begin
      if (n == gap_at) repeat (5) tick();
      send_sample(base + n, n == 0, done_last && (n == cnt - 1));
    end
  endtask

  task automatic pulse_done();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
  endtask

  task automatic read_bank(input int base, input int cnt);
    logic [2*DW-1:0] exp;
    for (int a = 0; a < cnt; a++) begin
      int n;
      n = base + int'(sample_of(6'(a)));
      rd_en   = 1'b1;
      rd_addr = 6'(a);
      sb_q.push_back({DW'(n), DW'(-n)});
      tick();
      exp = sb_q.pop_front();
      check($sformatf("rd[%0d]@%0d", a, base), {rd_re, rd_im}, exp);
    end
    rd_en = 1'b0;
  endtask

  task automatic check_handoff(input string tag, input logic sel);
    check({tag, "_ready_early"}, bank_ready, 0);
    tick();
    check({tag, "_ready"}, bank_ready, 1);
    check({tag, "_sel"}, bank_sel, sel);
    check({tag, "_busy"}, engine_busy, 1);
  endtask

  initial begin
    int r0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_ready", bank_ready, 0);
    check("rst_sel", bank_sel, 0);
    check("rst_busy", engine_busy, 0);
    check("rst_rd", {rd_re, rd_im}, 0);
    check("rst_ovf", overflow, 0);

    // Reading with no busy bank yields zero.
    rd_en = 1'b1; rd_addr = 6'd5; tick(); rd_en = 1'b0;
    check("rd_idle", {rd_re, rd_im}, 0);

    // First frame into bank 0.
    send_frame(0, 64, 1'b0, -1);
    check_handoff("f1", 1'b0);
    read_bank(0, 64);

    // Second frame fills bank 1 without hand-off; third is dropped.
    r0 = rdy_cnt;
    send_frame(100, 64, 1'b0, -1);
    repeat (3) tick();
    check("f2_no_ready", rdy_cnt, r0);
    check("f2_sel_hold", bank_sel, 0);
    check("ovf_before", overflow, 0);
    send_sample(999, 1'b1, 1'b0);
    check("ovf_set", overflow, 1);
    pulse_done();
    check("done_busy_low", engine_busy, 0);
    tick();
    check("f2_ready", bank_ready, 1);
    check("f2_sel", bank_sel, 1);
    read_bank(100, 64);

    // Restart at wr_cnt=20 into bank 0.
    pulse_done();
    repeat (2) tick();
    r0 = rdy_cnt;
    send_frame(200, 20, 1'b0, -1);
    send_frame(300, 63, 1'b0, -1);
    repeat (2) tick();
    check("rs_no_ready", rdy_cnt, r0);
    send_sample(363, 1'b0, 1'b0);
    check_handoff("rs", 1'b0);
    read_bank(300, 64);

    // fft_done coincides with the last sample of the next frame.
    send_frame(400, 64, 1'b1, -1);
    check_handoff("co", 1'b1);
    read_bank(400, 8);

    // Gap in din_valid mid-frame.
    pulse_done();
    send_frame(500, 64, 1'b0, 30);
    check_handoff("gap", 1'b0);
    read_bank(500, 64);

    // Reset while bank 0 busy and bank 1 mid-fill, with overflow still sticky.
    send_frame(600, 10, 1'b0, -1);
    check("pre_rst_ovf", overflow, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_ready", bank_ready, 0);
    check("rst2_sel", bank_sel, 0);
    check("rst2_busy", engine_busy, 0);
    check("rst2_rd", {rd_re, rd_im}, 0);
    check("rst2_ovf", overflow, 0);
    send_frame(700, 64, 1'b0, -1);
    check_handoff("post", 1'b0);
    read_bank(700, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft_input_buffer.md
# fft_input_buffer

Ping-pong sample buffer that sits directly downstream of the input sample counter. It captures 64 complex samples per frame into one of two 64-entry banks, optionally in bit-reversed order, and presents a full bank to the radix-2 butterfly engine. While the engine reads one bank, the next frame fills the other, so frame acquisition and FFT computation overlap.

## Interface
- DW, 16, width of each real/imaginary component (two's complement)
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset rst, synchronous, active-high
- frame_start  in  1  one-cycle pulse; qualifies the first sample of a frame (sample 0 arrives on the same cycle)
- din_valid  in  1  sample strobe; din_re/din_im are valid
- din_re, din_im  in  DW  input sample
- bank_ready  out  1  one-cycle pulse: a bank has just become full and is handed to the engine
- bank_sel  out  1  index of the bank currently owned by the engine (valid while engine_busy)
- engine_busy  out  1  high from bank_ready until fft_done
- rd_en  in  1  engine read request
- rd_addr  in  6  engine read address
- rd_re, rd_im  out  DW  read data, registered
- fft_done  in  1  one-cycle pulse: engine releases its bank
- overflow  out  1  sticky: a frame was dropped because both banks were full

## Operation
- Storage: two banks × 64 entries × 2·DW bits. Bank states: EMPTY, FILLING, FULL, BUSY.
- Write FSM:
  - IDLE: wait for frame_start with din_valid. Pick the lowest-index EMPTY bank, mark it FILLING, write sample 0, set wr_cnt=1, then go to FILL. If no bank is EMPTY, drop the frame, set overflow, and stay in IDLE.
  - FILL: each din_valid writes at addr(wr_cnt), then wr_cnt increments (6-bit). The write with wr_cnt==63 completes the frame: the bank becomes FULL and the FSM returns to IDLE.
  - din_valid without frame_start in IDLE: ignored.
  - frame_start in FILL (restart): the partial frame is discarded. The same bank restarts at wr_cnt=0 and the current sample is written as sample 0.
- Address map: addr(n) = bitrev6(n) when BITREV_EN is defined, otherwise n.
- Hand-off: when no bank is BUSY and a bank is FULL, that bank becomes BUSY, bank_sel is set to it, and bank_ready pulses. If both banks are FULL, the lower index goes first.
- Read: rd_en with rd_addr returns the BUSY bank's entry on rd_re/rd_im the next cycle. rd_en with no bank BUSY returns 0.
- fft_done: the BUSY bank becomes EMPTY and engine_busy drops. fft_done with no BUSY bank is ignored.
- Reset values: bank_ready=0, bank_sel=0, engine_busy=0, rd_re=rd_im=0, overflow=0. Both banks are EMPTY, the write FSM is in IDLE, wr_cnt=0. Memory contents are not reset.
- Reset mid-fill or mid-read aborts all frames. Engine data read after reset is undefined until the next bank_ready.

## Timing
- Sample write latency: data is written on the clock edge where din_valid is sampled.
- Last sample (edge N) makes the bank FULL. If the engine is idle, bank_ready and engine_busy go high on edge N+1 (visible after it); otherwise they assert the cycle after fft_done.
- Read latency: 1 cycle from rd_en to rd_re/rd_im.
- fft_done on edge M frees the bank on edge M. A waiting FULL bank is handed off on edge M+1, with bank_ready visible after M+1.
- fft_done and last-sample write in the same cycle are both honoured. The freshly full bank is handed off on the following edge.
- frame_start landing in the cycle a bank is freed by fft_done is not a conflict: bank state is evaluated before that edge's update, so the frame is dropped only if no bank was EMPTY before the edge.
- Gaps in din_valid within a frame are allowed; wr_cnt holds.

## Configuration
- FFT_INPUT_BITREV_EN defined: writes use bit-reversed addresses (sample n is stored at bitrev6(n)). The engine reads natural-order addresses for a decimation-in-time FFT.
- Not defined: writes use natural order (sample n is stored at n). The engine handles reordering.

## Test plan
- Reset, then one frame of samples re=n, im=−n for n=0..63 → bank_ready one cycle after sample 63, with bank_sel=0. With BITREV_EN defined, rd_addr=1 returns re=32 one cycle later; without it, it returns re=1.
- Back-to-back frames with no fft_done → second frame fills bank 1 and no bank_ready fires. A third frame_start → frame dropped, overflow=1. After fft_done, bank 1 is handed off with bank_ready.
- frame_start at wr_cnt=20 → partial frame discarded. New sample 0 is stored in the same bank, and bank_ready fires only after 64 further samples.
- fft_done in the same cycle as the last sample of the next frame → bank_ready on the following cycle, with bank_sel equal to the other bank.
- din_valid low for 5 cycles mid-frame → wr_cnt holds and all 64 samples read back correctly.
- rst asserted mid-fill and while engine_busy → all outputs return to reset values the next cycle, and overflow is cleared.
